// File: rtl/hazard_pkg.sv
// Shared encodings, FSM state constants and stage record type for the hazard/forwarding controller.
// Pure declarations; no timing or flow-control behaviour.
package hazard_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef logic [1:0] fsm_state_t;
  localparam fsm_state_t ST_RUN      = 2'd0;
  localparam fsm_state_t ST_LU_STALL = 2'd1;
  localparam fsm_state_t ST_BR_FLUSH = 2'd2;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_read;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } stage_rec_t;

  localparam stage_rec_t BUBBLE = '0;

  // x0 is hardwired to zero, so a write to it never produces a forwardable value.
  function automatic logic wr_hit(input logic wr, input logic [4:0] rd, input logic [4:0] src);
    return wr && (rd != 5'd0) && (rd == src);
  endfunction

endpackage

// File: rtl/fwd_cmp.sv
// Priority forward-select for one EX operand: youngest producer (MEM) wins over WB.
// Purely combinational, zero latency; no backpressure.
module fwd_cmp
  import hazard_pkg::*;
(
  input  logic       mem_wr,
  input  logic [4:0] mem_rd,
  input  logic       wb_wr,
  input  logic [4:0] wb_rd,
  input  logic [4:0] src,
  output logic [1:0] sel
);

  always_comb begin
    sel = FWD_RF;
    if (wr_hit(mem_wr, mem_rd, src)) begin
      sel = FWD_EXMEM;
    end else if (wr_hit(wb_wr, wb_rd, src)) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Pipeline hazard unit: operand forwarding, load-use stall and taken-branch flush.
// Controls are combinational from shadow records; mem_busy freezes records, FSM and enables.
module hazard_fwd_ctrl
  import hazard_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       id_valid,
  input  logic       id_reg_write,
  input  logic       id_mem_read,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] id_rd,
  input  logic       ex_branch_taken,
  input  logic       mem_busy,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       pc_sel,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       ifid_flush,
  output logic       idex_flush
);

  stage_rec_t ex_r, mem_r, wb_r;
  stage_rec_t id_rec;
  fsm_state_t state_r, state_nxt;
  logic       br_pend_r;
  logic       br_eff, load_use, stall;
  logic       mem_wr, wb_wr;

  assign id_rec = '{valid: id_valid, reg_write: id_reg_write, mem_read: id_mem_read,
                    rd: id_rd, rs1: id_rs1, rs2: id_rs2};

  assign mem_wr = mem_r.valid & mem_r.reg_write;
  assign wb_wr  = wb_r.valid & wb_r.reg_write;

  fwd_cmp u_fwd_a (
    .mem_wr (mem_wr),
    .mem_rd (mem_r.rd),
    .wb_wr  (wb_wr),
    .wb_rd  (wb_r.rd),
    .src    (ex_r.rs1),
    .sel    (fwd_a)
  );

  fwd_cmp u_fwd_b (
    .mem_wr (mem_wr),
    .mem_rd (mem_r.rd),
    .wb_wr  (wb_wr),
    .wb_rd  (wb_r.rd),
    .src    (ex_r.rs2),
    .sel    (fwd_b)
  );

  // A branch seen while frozen is remembered and acted on once the freeze lifts.
  assign br_eff   = ex_branch_taken | br_pend_r;
  assign load_use = id_valid && ex_r.valid && ex_r.mem_read && (ex_r.rd != 5'd0) &&
                    ((ex_r.rd == id_rs1) || (ex_r.rd == id_rs2));
  assign stall    = load_use && (state_r != ST_LU_STALL);

  always_comb begin
    pc_sel     = 1'b0;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    state_nxt  = ST_RUN;
    if (mem_busy) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      state_nxt  = state_r;
    end else if (br_eff) begin
      pc_sel     = 1'b1;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      state_nxt  = ST_BR_FLUSH;
    end else if (stall) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
      state_nxt  = ST_LU_STALL;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_r      <= BUBBLE;
      mem_r     <= BUBBLE;
      wb_r      <= BUBBLE;
      state_r   <= ST_RUN;
      br_pend_r <= 1'b0;
    end else if (mem_busy) begin
      br_pend_r <= br_pend_r | ex_branch_taken;
    end else begin
      ex_r      <= idex_flush ? BUBBLE : id_rec;
      mem_r     <= ex_r;
      wb_r      <= mem_r;
      state_r   <= state_nxt;
      br_pend_r <= 1'b0;
    end
  end

  // WB source indices and load flag are retained in the record but not consumed here.
  logic unused_wb_fields;
  assign unused_wb_fields = ^{wb_r.mem_read, wb_r.rs1, wb_r.rs2};

endmodule
